fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: maximum REQ-state cycles without FETCH_MEM_ACK before a fetch error (1..255).
REQ-002 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 FETCH_EN  input  1  control FSM permits the next fetch.
REQ-005 FETCH_PC  input  32  current PC from the PC register.
REQ-006 FETCH_REDIRECT  input  1  branch/jump/trap redirect strobe, one cycle.
REQ-007 FETCH_REDIRECT_PC  input  32  redirect target, valid with FETCH_REDIRECT.
REQ-008 FETCH_MEM_ACK  input  1  memory read data valid.
REQ-009 FETCH_MEM_RDATA  input  32  memory read data.
REQ-010 FETCH_MEM_REQ  output  1  instruction read request.
REQ-011 FETCH_MEM_ADDR  output  32  read address, registered.
REQ-012 FETCH_IR  output  32  latched instruction.
REQ-013 FETCH_IR_VALID  output  1  one-cycle pulse: FETCH_IR holds a new, non-killed instruction.
REQ-014 FETCH_PC_LD  output  1  one-cycle load strobe to the PC register.
REQ-015 FETCH_PC_NEXT  output  32  value for the PC register to load on FETCH_PC_LD.
REQ-016 FETCH_BUSY  output  1  high in any state other than IDLE.
REQ-017 FETCH_ERR  output  1  sticky fetch error: misaligned PC or timeout.

Function
REQ-018 States SHALL be IDLE, REQ, DONE, ERR; all outputs registered or decoded from state only.
REQ-019 IDLE: FETCH_REDIRECT takes priority: latch target, set kill, go DONE; else FETCH_EN with FETCH_PC[1:0]==0: latch FETCH_PC into FETCH_MEM_ADDR, go REQ; else FETCH_EN with FETCH_PC[1:0]!=0: go ERR.
REQ-020 REQ: FETCH_MEM_REQ=1; FETCH_MEM_ADDR stable; on FETCH_MEM_ACK latch FETCH_MEM_RDATA into FETCH_IR, go DONE.
REQ-021 FETCH_REDIRECT in REQ SHALL latch target and set kill; request continues until ACK; FETCH_IR still latched but never flagged valid.
REQ-022 DONE (exactly one cycle): FETCH_PC_LD=1; FETCH_PC_NEXT = kill ? latched target : FETCH_MEM_ADDR+4 (mod 2^32, wrap 0xFFFFFFFC->0); FETCH_IR_VALID = !kill; clear kill; go IDLE.
REQ-023 FETCH_REDIRECT in DONE SHALL be latched as pending and serviced in the following IDLE cycle as in REQ-019.
REQ-024 ERR: FETCH_ERR=1, no memory request; stay until FETCH_REDIRECT, which clears FETCH_ERR, latches target, sets kill, goes DONE.
REQ-025 Latency: FETCH_EN sampled in IDLE cycle n -> REQ from n+1; ACK in cycle k -> FETCH_IR_VALID and FETCH_PC_LD in cycle k+1.
REQ-026 ACK and FETCH_REDIRECT in the same REQ cycle: instruction killed, DONE loads redirect target.
REQ-027 Redirect targets SHALL be passed through unmodified; misalignment is detected on the next fetch.

Reset
REQ-028 RST SHALL immediately force state IDLE, FETCH_MEM_REQ=0, FETCH_MEM_ADDR=0, FETCH_IR=0, FETCH_IR_VALID=0, FETCH_PC_LD=0, FETCH_PC_NEXT=0, FETCH_BUSY=0, FETCH_ERR=0, kill/pending/timeout counter cleared.
REQ-029 RST asserted mid-REQ SHALL drop FETCH_MEM_REQ without waiting for ACK; a late ACK after reset SHALL be ignored.

Configuration
REQ-030 Macro FETCH_TIMEOUT_EN defined: 8-bit counter clears on REQ entry, increments each REQ cycle without ACK; reaching TIMEOUT_CYCLES goes ERR (ACK in that same cycle wins).
REQ-031 FETCH_TIMEOUT_EN undefined: no counter; REQ waits indefinitely for ACK.

Verification
REQ-032 Reset, FETCH_PC=0x0, FETCH_EN=1, ACK 2 cycles after REQ with 0x00000013 -> FETCH_IR=0x00000013, IR_VALID and PC_LD pulse once, PC_NEXT=0x4.
REQ-033 FETCH_PC=0x102, FETCH_EN=1 -> no FETCH_MEM_REQ, FETCH_ERR=1 held; REDIRECT to 0x200 -> FETCH_ERR=0, PC_LD with PC_NEXT=0x200, IR_VALID=0.
REQ-034 FETCH_PC=0x40, REDIRECT to 0x80 during REQ, ACK later -> IR_VALID stays 0, PC_NEXT=0x80.
REQ-035 FETCH_PC=0xFFFFFFFC, ACK -> PC_NEXT=0x00000000.
REQ-036 FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=15, no ACK -> FETCH_ERR rises 15 cycles after REQ entry, FETCH_MEM_REQ drops; RST mid-REQ -> all outputs 0 same cycle.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch unit handshake bundle: PC/redirect inputs, instruction-memory read port,
// and the instruction/PC-load outputs toward the core.
interface fetch_unit_if;
  logic        FETCH_EN;
  logic [31:0] FETCH_PC;
  logic        FETCH_REDIRECT;
  logic [31:0] FETCH_REDIRECT_PC;
  logic        FETCH_MEM_ACK;
  logic [31:0] FETCH_MEM_RDATA;
  logic        FETCH_MEM_REQ;
  logic [31:0] FETCH_MEM_ADDR;
  logic [31:0] FETCH_IR;
  logic        FETCH_IR_VALID;
  logic        FETCH_PC_LD;
  logic [31:0] FETCH_PC_NEXT;
  logic        FETCH_BUSY;
  logic        FETCH_ERR;

  modport master (
    input  FETCH_EN, FETCH_PC, FETCH_REDIRECT, FETCH_REDIRECT_PC,
    input  FETCH_MEM_ACK, FETCH_MEM_RDATA,
    output FETCH_MEM_REQ, FETCH_MEM_ADDR, FETCH_IR, FETCH_IR_VALID,
    output FETCH_PC_LD, FETCH_PC_NEXT, FETCH_BUSY, FETCH_ERR
  );

  modport slave (
    output FETCH_EN, FETCH_PC, FETCH_REDIRECT, FETCH_REDIRECT_PC,
    output FETCH_MEM_ACK, FETCH_MEM_RDATA,
    input  FETCH_MEM_REQ, FETCH_MEM_ADDR, FETCH_IR, FETCH_IR_VALID,
    input  FETCH_PC_LD, FETCH_PC_NEXT, FETCH_BUSY, FETCH_ERR
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch FSM (IDLE/REQ/DONE/ERR) with redirect kill and sticky error.
// Optional REQ-state timeout is enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input logic         CLK,
  input logic         RST,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  if ((TIMEOUT_CYCLES == 32'd0) || (TIMEOUT_CYCLES > 32'd255)) begin : g_timeout_range
    $error("fetch_unit: TIMEOUT_CYCLES must be within 1..255");
  end

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] ir_q, ir_d;
  logic        ir_valid_q, ir_valid_d;
  logic        pc_ld_q, pc_ld_d;
  logic [31:0] pc_next_q, pc_next_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        kill_q, kill_d;
  logic        pending_q, pending_d;
  logic [31:0] target_q, target_d;

  logic [31:0] redir_tgt_s;
  logic        kill_now_s;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] cnt_q, cnt_d;
`endif

  // A live redirect strobe always beats an older latched target.
  assign redir_tgt_s = bus.FETCH_REDIRECT ? bus.FETCH_REDIRECT_PC : target_q;
  assign kill_now_s  = kill_q | bus.FETCH_REDIRECT;

  // Next-state and next-output decode.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    ir_d       = ir_q;
    ir_valid_d = 1'b0;
    pc_ld_d    = 1'b0;
    pc_next_d  = pc_next_q;
    busy_d     = busy_q;
    err_d      = err_q;
    kill_d     = kill_q;
    pending_d  = pending_q;
    target_d   = target_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.FETCH_REDIRECT || pending_q) begin
          target_d  = redir_tgt_s;
          kill_d    = 1'b1;
          pending_d = 1'b0;
          pc_ld_d   = 1'b1;
          pc_next_d = redir_tgt_s;
          busy_d    = 1'b1;
          state_d   = DONE;
        end else if (bus.FETCH_EN) begin
          busy_d = 1'b1;
          if (bus.FETCH_PC[1:0] == 2'b00) begin
            mem_addr_d = bus.FETCH_PC;
            mem_req_d  = 1'b1;
            state_d    = REQ;
`ifdef FETCH_TIMEOUT_EN
            cnt_d      = 8'd0;
`endif
          end else begin
            err_d   = 1'b1;
            state_d = ERR;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      REQ: begin
        if (bus.FETCH_REDIRECT) begin
          target_d = bus.FETCH_REDIRECT_PC;
          kill_d   = 1'b1;
        end else begin
          target_d = target_q;
        end
        if (bus.FETCH_MEM_ACK) begin
          ir_d       = bus.FETCH_MEM_RDATA;
          mem_req_d  = 1'b0;
          pc_ld_d    = 1'b1;
          pc_next_d  = kill_now_s ? redir_tgt_s : (mem_addr_q + 32'd4);
          ir_valid_d = ~kill_now_s;
          state_d    = DONE;
        end else begin
`ifdef FETCH_TIMEOUT_EN
          // ACK in the limit cycle is taken above, so it wins over the timeout.
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TIMEOUT_LIMIT) begin
            mem_req_d = 1'b0;
            err_d     = 1'b1;
            state_d   = ERR;
          end else begin
            state_d = REQ;
          end
`else
          state_d = REQ;
`endif
        end
      end
      DONE: begin
        kill_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
        // Redirect arriving while the PC load is in flight is replayed from IDLE.
        if (bus.FETCH_REDIRECT) begin
          pending_d = 1'b1;
          target_d  = bus.FETCH_REDIRECT_PC;
        end else begin
          pending_d = pending_q;
        end
      end
      ERR: begin
        if (bus.FETCH_REDIRECT) begin
          err_d     = 1'b0;
          target_d  = bus.FETCH_REDIRECT_PC;
          kill_d    = 1'b1;
          pc_ld_d   = 1'b1;
          pc_next_d = bus.FETCH_REDIRECT_PC;
          state_d   = DONE;
        end else begin
          err_d = 1'b1;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset also abandons any outstanding request.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'd0;
      ir_q       <= 32'd0;
      ir_valid_q <= 1'b0;
      pc_ld_q    <= 1'b0;
      pc_next_q  <= 32'd0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      kill_q     <= 1'b0;
      pending_q  <= 1'b0;
      target_q   <= 32'd0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      pc_ld_q    <= pc_ld_d;
      pc_next_q  <= pc_next_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      kill_q     <= kill_d;
      pending_q  <= pending_d;
      target_q   <= target_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign bus.FETCH_MEM_REQ  = mem_req_q;
  assign bus.FETCH_MEM_ADDR = mem_addr_q;
  assign bus.FETCH_IR       = ir_q;
  assign bus.FETCH_IR_VALID = ir_valid_q;
  assign bus.FETCH_PC_LD    = pc_ld_q;
  assign bus.FETCH_PC_NEXT  = pc_next_q;
  assign bus.FETCH_BUSY     = busy_q;
  assign bus.FETCH_ERR      = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected PC loads are queued as stimulus is
// driven and popped whenever the DUT strobes FETCH_PC_LD.
module tb_fetch_unit;

  typedef struct packed {
    logic        valid;
    logic [31:0] ir;
    logic [31:0] pc_next;
  } exp_t;

  logic clk;
  logic rst;
  fetch_unit_if bus_if();

  exp_t exp_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   pc_ld_cnt = 0;
  int   push_cnt  = 0;

  fetch_unit #(.TIMEOUT_CYCLES(15)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic valid, input logic [31:0] ir, input logic [31:0] pc_next);
    exp_t e;
    e.valid   = valid;
    e.ir      = ir;
    e.pc_next = pc_next;
    exp_q.push_back(e);
    push_cnt++;
  endtask

  // Advance one cycle, then score any PC-load strobe against the queue.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus_if.FETCH_PC_LD === 1'b1) begin
      pc_ld_cnt++;
      chk("sb_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_ir_valid", 32'(bus_if.FETCH_IR_VALID), 32'(e.valid));
        chk("sb_pc_next", bus_if.FETCH_PC_NEXT, e.pc_next);
        if (e.valid) chk("sb_ir", bus_if.FETCH_IR, e.ir);
      end
    end else if (bus_if.FETCH_IR_VALID !== 1'b0) begin
      chk("ir_valid_without_pc_ld", 32'(bus_if.FETCH_IR_VALID), 32'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"}, 32'(bus_if.FETCH_MEM_REQ), 32'd0);
    chk({tag, "_mem_addr"}, bus_if.FETCH_MEM_ADDR, 32'd0);
    chk({tag, "_ir"}, bus_if.FETCH_IR, 32'd0);
    chk({tag, "_ir_valid"}, 32'(bus_if.FETCH_IR_VALID), 32'd0);
    chk({tag, "_pc_ld"}, 32'(bus_if.FETCH_PC_LD), 32'd0);
    chk({tag, "_pc_next"}, bus_if.FETCH_PC_NEXT, 32'd0);
    chk({tag, "_busy"}, 32'(bus_if.FETCH_BUSY), 32'd0);
    chk({tag, "_err"}, 32'(bus_if.FETCH_ERR), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus_if.FETCH_EN          = 1'b0;
    bus_if.FETCH_PC          = 32'd0;
    bus_if.FETCH_REDIRECT    = 1'b0;
    bus_if.FETCH_REDIRECT_PC = 32'd0;
    bus_if.FETCH_MEM_ACK     = 1'b0;
    bus_if.FETCH_MEM_RDATA   = 32'd0;
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;

    // Basic fetch from 0, ACK in the third REQ cycle.
    bus_if.FETCH_EN = 1'b1;
    bus_if.FETCH_PC = 32'h0000_0000;
    step();
    bus_if.FETCH_EN = 1'b0;
    chk("f0_mem_req", 32'(bus_if.FETCH_MEM_REQ), 32'd1);
    chk("f0_mem_addr", bus_if.FETCH_MEM_ADDR, 32'h0000_0000);
    chk("f0_busy", 32'(bus_if.FETCH_BUSY), 32'd1);
    step();
    chk("f0_req_hold", 32'(bus_if.FETCH_MEM_REQ), 32'd1);
    step();
    bus_if.FETCH_MEM_ACK   = 1'b1;
    bus_if.FETCH_MEM_RDATA = 32'h0000_0013;
    push(1'b1, 32'h0000_0013, 32'h0000_0004);
    step();
    bus_if.FETCH_MEM_ACK = 1'b0;
    chk("f0_done_pc_ld", 32'(bus_if.FETCH_PC_LD), 32'd1);
    chk("f0_done_ir", bus_if.FETCH_IR, 32'h0000_0013);
    chk("f0_done_mem_req", 32'(bus_if.FETCH_MEM_REQ), 32'd0);
    step();
    chk("f0_idle_pc_ld", 32'(bus_if.FETCH_PC_LD), 32'd0);
    chk("f0_idle_ir_valid", 32'(bus_if.FETCH_IR_VALID), 32'd0);
    chk("f0_idle_busy", 32'(bus_if.FETCH_BUSY), 32'd0);
    chk("f0_single_pulse", 32'(pc_ld_cnt), 32'd1);

    // Misaligned PC goes to ERR; redirect recovers.
    bus_if.FETCH_EN = 1'b1;
    bus_if.FETCH_PC = 32'h0000_0102;
    step();
    bus_if.FETCH_EN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("mis_err", 32'(bus_if.FETCH_ERR), 32'd1);
      chk("mis_no_req", 32'(bus_if.FETCH_MEM_REQ), 32'd0);
      step();
    end
    bus_if.FETCH_REDIRECT    = 1'b1;
    bus_if.FETCH_REDIRECT_PC = 32'h0000_0200;
    push(1'b0, 32'd0, 32'h0000_0200);
    step();
    bus_if.FETCH_REDIRECT = 1'b0;
    chk("mis_err_cleared", 32'(bus_if.FETCH_ERR), 32'd0);
    chk("mis_pc_ld", 32'(bus_if.FETCH_PC_LD), 32'd1);
    step();

    // Redirect during REQ, ACK two cycles later: killed.
    bus_if.FETCH_EN = 1'b1;
    bus_if.FETCH_PC = 32'h0000_0040;
    step();
    bus_if.FETCH_EN = 1'b0;
    chk("kill_addr", bus_if.FETCH_MEM_ADDR, 32'h0000_0040);
    bus_if.FETCH_REDIRECT    = 1'b1;
    bus_if.FETCH_REDIRECT_PC = 32'h0000_0080;
    step();
    bus_if.FETCH_REDIRECT = 1'b0;
    chk("kill_req_continues", 32'(bus_if.FETCH_MEM_REQ), 32'd1);
    chk("kill_addr_stable", bus_if.FETCH_MEM_ADDR, 32'h0000_0040);
    step();
    bus_if.FETCH_MEM_ACK   = 1'b1;
    bus_if.FETCH_MEM_RDATA = 32'hDEAD_BEEF;
    push(1'b0, 32'd0, 32'h0000_0080);
    step();
    bus_if.FETCH_MEM_ACK = 1'b0;
    chk("kill_ir_latched", bus_if.FETCH_IR, 32'hDEAD_BEEF);
    step();

    // ACK and redirect in the same REQ cycle.
    bus_if.FETCH_EN = 1'b1;
    bus_if.FETCH_PC = 32'h0000_0100;
    step();
    bus_if.FETCH_EN          = 1'b0;
    bus_if.FETCH_MEM_ACK     = 1'b1;
    bus_if.FETCH_MEM_RDATA   = 32'h0000_0011;
    bus_if.FETCH_REDIRECT    = 1'b1;
    bus_if.FETCH_REDIRECT_PC = 32'h0000_0300;
    push(1'b0, 32'd0, 32'h0000_0300);
    step();
    bus_if.FETCH_MEM_ACK  = 1'b0;
    bus_if.FETCH_REDIRECT = 1'b0;
    step();

    // PC wrap at the top of the address space.
    bus_if.FETCH_EN = 1'b1;
    bus_if.FETCH_PC = 32'hFFFF_FFFC;
    step();
    bus_if.FETCH_EN        = 1'b0;
    bus_if.FETCH_MEM_ACK   = 1'b1;
    bus_if.FETCH_MEM_RDATA = 32'h0000_0055;
    push(1'b1, 32'h0000_0055, 32'h0000_0000);
    step();
    bus_if.FETCH_MEM_ACK = 1'b0;
    step();

    // Redirect during DONE is held pending and replayed from IDLE.
    bus_if.FETCH_EN = 1'b1;
    bus_if.FETCH_PC = 32'h0000_0008;
    step();
    bus_if.FETCH_EN        = 1'b0;
    bus_if.FETCH_MEM_ACK   = 1'b1;
    bus_if.FETCH_MEM_RDATA = 32'h0000_0077;
    push(1'b1, 32'h0000_0077, 32'h0000_000C);
    step();
    bus_if.FETCH_MEM_ACK     = 1'b0;
    bus_if.FETCH_REDIRECT    = 1'b1;
    bus_if.FETCH_REDIRECT_PC = 32'h0000_0400;
    push(1'b0, 32'd0, 32'h0000_0400);
    step();
    bus_if.FETCH_REDIRECT = 1'b0;
    chk("pend_idle_busy", 32'(bus_if.FETCH_BUSY), 32'd0);
    step();
    chk("pend_done_pc_ld", 32'(bus_if.FETCH_PC_LD), 32'd1);
    step();

    // Redirect in IDLE beats FETCH_EN; misaligned target passes through.
    bus_if.FETCH_REDIRECT    = 1'b1;
    bus_if.FETCH_REDIRECT_PC = 32'h0000_1002;
    bus_if.FETCH_EN          = 1'b1;
    bus_if.FETCH_PC          = 32'h0000_0000;
    push(1'b0, 32'd0, 32'h0000_1002);
    step();
    bus_if.FETCH_REDIRECT = 1'b0;
    bus_if.FETCH_EN       = 1'b0;
    chk("idle_redir_no_req", 32'(bus_if.FETCH_MEM_REQ), 32'd0);
    step();
    bus_if.FETCH_EN = 1'b1;
    bus_if.FETCH_PC = 32'h0000_1002;
    step();
    bus_if.FETCH_EN = 1'b0;
    chk("idle_redir_late_err", 32'(bus_if.FETCH_ERR), 32'd1);
    bus_if.FETCH_REDIRECT    = 1'b1;
    bus_if.FETCH_REDIRECT_PC = 32'h0000_0000;
    push(1'b0, 32'd0, 32'h0000_0000);
    step();
    bus_if.FETCH_REDIRECT = 1'b0;
    step();

    // Long wait without ACK.
    bus_if.FETCH_EN = 1'b1;
    bus_if.FETCH_PC = 32'h0000_0020;
    step();
    bus_if.FETCH_EN = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 14; i++) begin
      chk("to_still_req", 32'(bus_if.FETCH_MEM_REQ), 32'd1);
      chk("to_no_err", 32'(bus_if.FETCH_ERR), 32'd0);
      step();
    end
    chk("to_last_req", 32'(bus_if.FETCH_MEM_REQ), 32'd1);
    step();
    chk("to_err", 32'(bus_if.FETCH_ERR), 32'd1);
    chk("to_req_dropped", 32'(bus_if.FETCH_MEM_REQ), 32'd0);
    bus_if.FETCH_REDIRECT    = 1'b1;
    bus_if.FETCH_REDIRECT_PC = 32'h0000_0000;
    push(1'b0, 32'd0, 32'h0000_0000);
    step();
    bus_if.FETCH_REDIRECT = 1'b0;
    step();
`else
    for (int i = 0; i < 30; i++) begin
      chk("nto_still_req", 32'(bus_if.FETCH_MEM_REQ), 32'd1);
      chk("nto_no_err", 32'(bus_if.FETCH_ERR), 32'd0);
      step();
    end
    bus_if.FETCH_MEM_ACK   = 1'b1;
    bus_if.FETCH_MEM_RDATA = 32'h0000_0ABC;
    push(1'b1, 32'h0000_0ABC, 32'h0000_0024);
    step();
    bus_if.FETCH_MEM_ACK = 1'b0;
    step();
`endif

    // Reset mid-REQ: outputs clear at once, a late ACK is ignored.
    bus_if.FETCH_EN = 1'b1;
    bus_if.FETCH_PC = 32'h0000_0060;
    step();
    bus_if.FETCH_EN = 1'b0;
    chk("rst_pre_req", 32'(bus_if.FETCH_MEM_REQ), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk_all_zero("rst_async");
    bus_if.FETCH_MEM_ACK   = 1'b1;
    bus_if.FETCH_MEM_RDATA = 32'h0000_0099;
    step();
    rst = 1'b0;
    step();
    bus_if.FETCH_MEM_ACK = 1'b0;
    chk("rst_late_ack_busy", 32'(bus_if.FETCH_BUSY), 32'd0);
    chk("rst_late_ack_ir", bus_if.FETCH_IR, 32'd0);
    step();
    chk("rst_late_ack_pc_ld", 32'(bus_if.FETCH_PC_LD), 32'd0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("pc_ld_total", 32'(pc_ld_cnt), 32'(push_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
